// File: rtl/adder_io_stage_if.sv
// Bus bundle for adder_io_stage: operand intake, the external adder link and result output.
// The stage uses the slave modport; the environment (producer, adder, consumer) uses master.
interface adder_io_stage_if #(
  parameter int K = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_a;
  logic [K-1:0] in_b;
  logic         in_cin;
  logic [K-1:0] add_a;
  logic [K-1:0] add_b;
  logic         add_cin;
  logic [K-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_sum;
  logic         out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/adder_io_stage.sv
// Registers operands into an external combinational adder, waits SETTLE cycles, then holds
// the captured sum until consumed. Define ADDER_OVF_FLAG_EN to add the signed-overflow output out_ovf.
module adder_io_stage #(
  parameter int K      = 8,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_io_stage_if.slave io,
  output logic            busy,
  output logic [15:0]     txn_cnt
`ifdef ADDER_OVF_FLAG_EN
  ,
  output logic            out_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic          in_ready_s;
  logic          accept_s;
  logic          capture_s;
  logic          complete_s;
  logic [K-1:0]  add_a_r;
  logic [K-1:0]  add_b_r;
  logic          add_cin_r;
  logic [K-1:0]  out_sum_r;
  logic          out_cout_r;
  logic [15:0]   txn_cnt_r;

  // Next-state decode and intake readiness
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (io.in_valid) state_nxt_s = LAUNCH;
        else             state_nxt_s = IDLE;
      end
      LAUNCH: begin
        if (cnt_r == CNT_LAST) state_nxt_s = HOLD;
        else                   state_nxt_s = LAUNCH;
      end
      HOLD: begin
        in_ready_s = io.out_ready;
        if (io.out_ready && io.in_valid) state_nxt_s = LAUNCH;
        else if (io.out_ready)           state_nxt_s = IDLE;
        else                             state_nxt_s = HOLD;
      end
      default: begin
        state_nxt_s = IDLE;
        in_ready_s  = 1'b0;
      end
    endcase
  end

  assign accept_s   = io.in_valid & in_ready_s;
  assign capture_s  = (state_r == LAUNCH) && (cnt_r == CNT_LAST);
  assign complete_s = (state_r == HOLD) && io.out_ready;

  // State register and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s)                               cnt_r <= '0;
      else if ((state_r == LAUNCH) && !capture_s) cnt_r <= cnt_r + CW'(1);
      else                                        cnt_r <= cnt_r;
    end
  end

  // Operand registers feeding the adder; only an accept may change them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r   <= '0;
      add_b_r   <= '0;
      add_cin_r <= 1'b0;
    end else if (accept_s) begin
      add_a_r   <= io.in_a;
      add_b_r   <= io.in_b;
      add_cin_r <= io.in_cin;
    end else begin
      add_a_r   <= add_a_r;
      add_b_r   <= add_b_r;
      add_cin_r <= add_cin_r;
    end
  end

  // Result capture once the adder has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_r  <= '0;
      out_cout_r <= 1'b0;
    end else if (capture_s) begin
      out_sum_r  <= io.add_sum;
      out_cout_r <= io.add_cout;
    end else begin
      out_sum_r  <= out_sum_r;
      out_cout_r <= out_cout_r;
    end
  end

  // Completed-result counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          txn_cnt_r <= 16'd0;
    else if (complete_s) txn_cnt_r <= txn_cnt_r + 16'd1;
    else                 txn_cnt_r <= txn_cnt_r;
  end

`ifdef ADDER_OVF_FLAG_EN
  logic out_ovf_r;

  // Two's-complement overflow: like-signed operands yielding an opposite-signed sum
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Overflow flag captured alongside the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_ovf_r <= 1'b0;
    else if (capture_s) out_ovf_r <= signed_ovf(add_a_r[K-1], add_b_r[K-1], io.add_sum[K-1]);
    else                out_ovf_r <= out_ovf_r;
  end

  assign out_ovf = out_ovf_r;
`endif

  assign io.in_ready  = in_ready_s;
  assign io.add_a     = add_a_r;
  assign io.add_b     = add_b_r;
  assign io.add_cin   = add_cin_r;
  assign io.out_valid = (state_r == HOLD);
  assign io.out_sum   = out_sum_r;
  assign io.out_cout  = out_cout_r;
  assign busy         = (state_r != IDLE);
  assign txn_cnt      = txn_cnt_r;

endmodule

// File: tb/tb_adder_io_stage.sv
// Directed self-checking bench for adder_io_stage (K=8, SETTLE=2); the external adder is
// modelled as a+b+cin. Overflow checks apply when ADDER_OVF_FLAG_EN is defined.
module tb_adder_io_stage;
  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] txn_cnt;
  logic        out_ovf;
  int          total;
  int          bad;

  adder_io_stage_if #(.K(8)) bus ();

  adder_io_stage #(.K(8), .SETTLE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus),
    .busy    (busy),
    .txn_cnt (txn_cnt)
`ifdef ADDER_OVF_FLAG_EN
    ,
    .out_ovf (out_ovf)
`endif
  );

`ifndef ADDER_OVF_FLAG_EN
  assign out_ovf = 1'b0;
`endif

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_cin = 1'b0;
    step(); step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (txn_cnt !== 16'h0000) begin bad++; $display("FAIL rst_txn_cnt: got %h want 0000", txn_cnt); end
    total++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 17'd0) begin bad++; $display("FAIL rst_add: got %h want 0", {bus.add_a, bus.add_b, bus.add_cin}); end
    total++; if ({bus.out_sum, bus.out_cout, out_ovf} !== 10'd0) begin bad++; $display("FAIL rst_out: got %h want 0", {bus.out_sum, bus.out_cout, out_ovf}); end
    rst_n = 1'b1;
  endtask

  // First edge after reset release accepts 7F+01
  task automatic test_overflow();
    bus.in_a = 8'h7F; bus.in_b = 8'h01; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.add_a !== 8'h7F || bus.add_b !== 8'h01) begin bad++; $display("FAIL ovf_add_load: got %h/%h want 7f/01", bus.add_a, bus.add_b); end
    total++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL ovf_launch: got busy=%b in_ready=%b want 1/0", busy, bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_early_valid: got %b want 0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_sum !== 8'h80 || bus.out_cout !== 1'b0) begin bad++; $display("FAIL ovf_sum: got %h/%b want 80/0", bus.out_sum, bus.out_cout); end
`ifdef ADDER_OVF_FLAG_EN
    total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", out_ovf); end
`endif
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (txn_cnt !== 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL ovf_done: got txn=%0d busy=%b want 1/0", txn_cnt, busy); end
    total++; if (bus.out_sum !== 8'h80) begin bad++; $display("FAIL ovf_retain: got %h want 80", bus.out_sum); end
  endtask

  // FF+01+1, with operand changes offered during LAUNCH that must be ignored
  task automatic test_carry();
    bus.in_a = 8'hFF; bus.in_b = 8'h01; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_a = 8'h55; bus.in_b = 8'h55; bus.in_cin = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL carry_launch_ready: got %b want 0", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.add_a !== 8'hFF || bus.add_b !== 8'h01 || bus.add_cin !== 1'b1) begin bad++; $display("FAIL carry_add_stable: got %h/%h/%b want ff/01/1", bus.add_a, bus.add_b, bus.add_cin); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h01 || bus.out_cout !== 1'b1) begin bad++; $display("FAIL carry_sum: got v=%b %h/%b want 1 01/1", bus.out_valid, bus.out_sum, bus.out_cout); end
`ifdef ADDER_OVF_FLAG_EN
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL carry_ovf: got %b want 0", out_ovf); end
`endif
    total++; if (txn_cnt !== 16'd1) begin bad++; $display("FAIL carry_txn_pre: got %0d want 1", txn_cnt); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    total++; if (txn_cnt !== 16'd2) begin bad++; $display("FAIL carry_txn_post: got %0d want 2", txn_cnt); end
  endtask

  task automatic test_hold_stall();
    bus.in_a = 8'h10; bus.in_b = 8'h20; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    bus.in_a = 8'hAA; bus.in_b = 8'h11; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h30) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b %h want 1 30", i, bus.out_valid, bus.out_sum); end
      total++; if (bus.in_ready !== 1'b0 || txn_cnt !== 16'd2) begin bad++; $display("FAIL stall_ready_txn[%0d]: got %b/%0d want 0/2", i, bus.in_ready, txn_cnt); end
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (txn_cnt !== 16'd3 || busy !== 1'b0) begin bad++; $display("FAIL stall_release: got txn=%0d busy=%b want 3/0", txn_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va  [4] = '{8'h01, 8'h80, 8'h40, 8'hF0};
    logic [7:0] vb  [4] = '{8'h02, 8'h80, 8'h40, 8'h0F};
    logic       vc  [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] es  [4] = '{8'h03, 8'h00, 8'h81, 8'h00};
    logic       eco [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic       eov [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
    int acc_cyc [4];
    int k = 0;
    int r = 0;
    int cyc = 0;
    logic acc;
    bus.out_ready = 1'b1;
    while (r < 4 && cyc < 40) begin
      bus.in_valid = (k < 4);
      if (k < 4) begin bus.in_a = va[k]; bus.in_b = vb[k]; bus.in_cin = vc[k]; end
      acc = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (acc) begin acc_cyc[k] = cyc; k++; end
      if (bus.out_valid === 1'b1) begin
        total++; if (bus.out_sum !== es[r] || bus.out_cout !== eco[r]) begin bad++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", r, bus.out_sum, bus.out_cout, es[r], eco[r]); end
`ifdef ADDER_OVF_FLAG_EN
        total++; if (out_ovf !== eov[r]) begin bad++; $display("FAIL b2b_ovf[%0d]: got %b want %b", r, out_ovf, eov[r]); end
`endif
        total++; if (cyc - acc_cyc[r] != 2) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 2", r, cyc - acc_cyc[r]); end
        r++;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d]: got %b want 1", cyc, busy); end
    end
    total++; if (r != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", r); end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    total++; if (txn_cnt !== 16'd7 || busy !== 1'b0) begin bad++; $display("FAIL b2b_txn: got %0d busy=%b want 7/0", txn_cnt, busy); end
  endtask

  task automatic test_reset_launch();
    bus.in_a = 8'h11; bus.in_b = 8'h22; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rl_state: got busy=%b rdy=%b v=%b want 0/1/0", busy, bus.in_ready, bus.out_valid); end
    total++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 17'd0 || {bus.out_sum, bus.out_cout, out_ovf} !== 10'd0) begin bad++; $display("FAIL rl_regs: got %h %h want 0 0", {bus.add_a, bus.add_b, bus.add_cin}, {bus.out_sum, bus.out_cout, out_ovf}); end
    total++; if (txn_cnt !== 16'd0) begin bad++; $display("FAIL rl_txn: got %0d want 0", txn_cnt); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rl_no_result[%0d]: got v=%b busy=%b want 0/0", i, bus.out_valid, busy); end
    end
  endtask

  task automatic test_wrap();
    force dut.txn_cnt_r = 16'hFFFF;
    #1;
    release dut.txn_cnt_r;
    total++; if (txn_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", txn_cnt); end
    bus.in_a = 8'h05; bus.in_b = 8'h06; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h0B || txn_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_result: got v=%b %h txn=%h want 1 0b ffff", bus.out_valid, bus.out_sum, txn_cnt); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (txn_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_txn: got %h want 0000", txn_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_overflow();
    test_carry();
    test_hold_stall();
    test_back_to_back();
    test_reset_launch();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
